// File: rtl/fu_issue_seq.sv
// Serialising request sequencer in front of the FU: writes ALUOP, OP1, OP2, waits for
// result-valid, reads op3 and returns it. Optional result watchdog under `FU_TIMEOUT_EN`.
module fu_issue_seq #(
  parameter int unsigned DBITS          = 32,
  parameter int unsigned ALUOPBITS      = 4,
  parameter int unsigned TAGBITS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ALUOPBITS-1:0] req_aluop,
  input  logic [DBITS-1:0]     req_op1,
  input  logic [DBITS-1:0]     req_op2,
  input  logic [TAGBITS-1:0]   req_tag,
  output logic [DBITS+3:0]     to_fu,
  input  logic [DBITS+2:0]     from_fu,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DBITS-1:0]     rsp_data,
  output logic [TAGBITS-1:0]   rsp_tag,
  output logic                 rsp_err,
  output logic                 fu_hung
);

  typedef enum logic [2:0] {
    IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, READ, RESP
  } state_e;

  state_e               state_q, state_d;
  logic [DBITS-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [DBITS-1:0]     wr_data_q, wr_data_d, rsp_data_q, rsp_data_d;
  logic [TAGBITS-1:0]   tag_q, tag_d;
  logic [2:0]           wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic                 req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                 res_valid, accept;

  assign res_valid = from_fu[DBITS+2];
  assign accept    = req_valid && req_ready_q;

  logic unused_csr;
  assign unused_csr = ^from_fu[DBITS+1:DBITS];

`ifdef FU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d, hung_q, hung_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
`ifdef FU_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    hung_d     = hung_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEND_OP;
        op1_d   = req_op1;
        op2_d   = req_op2;
        tag_d   = req_tag;
`ifdef FU_TIMEOUT_EN
        rsp_err_d = 1'b0;
`endif
      end
      SEND_OP: state_d = SEND_A;
      SEND_A:  state_d = SEND_B;
      SEND_B: begin
        state_d = WAIT_RES;
`ifdef FU_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      // A result arriving on the limit cycle still takes the normal path.
      WAIT_RES: if (res_valid) begin
        state_d    = READ;
        rsp_data_d = from_fu[DBITS-1:0];
      end
`ifdef FU_TIMEOUT_EN
      else if (cnt_q == TMO_LAST) begin
        state_d    = RESP;
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        hung_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`endif
      READ:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore outputs are decoded from the next state so they come straight from flops.
    wr_d      = '0;
    rd_d      = 1'b0;
    wr_data_d = '0;
    case (state_d)
      SEND_OP: begin wr_d = 3'b001; wr_data_d = DBITS'(req_aluop); end
      SEND_A:  begin wr_d = 3'b010; wr_data_d = op1_q; end
      SEND_B:  begin wr_d = 3'b100; wr_data_d = op2_q; end
      READ:    rd_d = 1'b1;
      default: ;
    endcase
    rsp_valid_d = (state_d == RESP);
`ifdef FU_TIMEOUT_EN
    req_ready_d = (state_d == IDLE) && !hung_d;
`else
    req_ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      tag_q       <= '0;
      rsp_data_q  <= '0;
      wr_q        <= '0;
      rd_q        <= 1'b0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      tag_q       <= tag_d;
      rsp_data_q  <= rsp_data_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

`ifdef FU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      hung_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
      hung_q    <= hung_d;
    end
  end
  assign rsp_err = rsp_err_q;
  assign fu_hung = hung_q;
`else
  assign rsp_err = 1'b0;
  assign fu_hung = 1'b0;
`endif

  assign to_fu     = {rd_q, wr_data_q, wr_q};
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_fu_issue_seq.sv
// Scoreboard bench for fu_issue_seq: directed requests, an FU stub answering after a
// programmable delay, and a monitor checking responses in order.
module tb_fu_issue_seq;
  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [3:0]    req_aluop, req_tag;
  logic [DB-1:0] req_op1, req_op2;
  logic [DB+3:0] to_fu;
  logic [DB+2:0] from_fu;
  logic          rsp_valid, rsp_ready, rsp_err, fu_hung;
  logic [DB-1:0] rsp_data;
  logic [3:0]    rsp_tag;

  fu_issue_seq #(.DBITS(DB), .ALUOPBITS(4), .TAGBITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .to_fu(to_fu), .from_fu(from_fu),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .fu_hung(fu_hung)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [3:0]    tag;
    logic [DB-1:0] data;
  } sb_t;

  sb_t           sb_q[$];
  sb_t           mon_e;
  logic [DB-1:0] fu_res_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            hs_cyc = -1;
  int            acc_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FU stub: raises result-valid stub_delay cycles after wr_op2, drops it on rd_op3.
  logic          fu_csr = 1'b0;
  logic [DB-1:0] fu_op3 = '0;
  int            stub_cnt = -1;
  int            stub_delay = 1;
  bit            stub_en = 1'b1;
  bit            stale_en = 1'b0;
  assign from_fu = {fu_csr, 2'b00, fu_op3};

  always @(negedge clk) begin
    if (reset) begin
      stub_cnt = -1;
      fu_csr   = 1'b0;
      fu_op3   = '0;
    end else begin
      if (to_fu[DB+3]) begin
        fu_csr = 1'b0;
        fu_op3 = '0;
      end
      if (stale_en && to_fu[1]) begin
        fu_csr   = 1'b1;
        fu_op3   = 32'hDEAD_BEEF;
        stale_en = 1'b0;
      end else if (to_fu[2]) begin
        fu_csr = 1'b0;
        fu_op3 = '0;
        if (stub_en) stub_cnt = stub_delay;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_cnt = -1;
          if (fu_res_q.size() != 0) begin
            fu_csr = 1'b1;
            fu_op3 = fu_res_q.pop_front();
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each visible handshake.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got tag 0x%0h data 0x%0h, expected no response", rsp_tag, rsp_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_tag", rsp_tag, mon_e.tag);
        check("rsp_err", rsp_err, mon_e.err);
      end
      hs_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!reset && (to_fu[DB+3] || |to_fu[2:0]))
      check("one_strobe", $countones({to_fu[DB+3], to_fu[2:0]}), 1);
  end

  task automatic issue(input logic [3:0] op, input logic [DB-1:0] a, input logic [DB-1:0] b,
                       input logic [3:0] tag, input logic [DB-1:0] res, input bit err, input bit push);
    bit accepted = 1'b0;
    req_aluop = op; req_op1 = a; req_op2 = b; req_tag = tag; req_valid = 1'b1;
    if (push) begin
      sb_q.push_back({err, tag, res});
      if (!err) fu_res_q.push_back(res);
    end
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 200 cycles, expected acceptance (tag 0x%0h)", tag);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [DB+3:0] exp_fu;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_to_fu", to_fu, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_fu_hung", fu_hung, 0);
    check("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single op, result-valid in cycle 7.
    rsp_ready = 1'b1; stub_delay = 4;
    issue(4'h1, 32'h5, 32'h7, 4'h3, 32'hC, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      case (c)
        1:       exp_fu = {1'b0, 32'h1, 3'b001};
        2:       exp_fu = {1'b0, 32'h5, 3'b010};
        3:       exp_fu = {1'b0, 32'h7, 3'b100};
        8:       exp_fu = {1'b1, 32'h0, 3'b000};
        default: exp_fu = '0;
      endcase
      check($sformatf("t1_to_fu_c%0d", c), to_fu, exp_fu);
      check($sformatf("t1_req_ready_c%0d", c), req_ready, (c == 10));
      check($sformatf("t1_rsp_valid_c%0d", c), rsp_valid, (c == 9));
    end
    @(posedge clk); #1;

    // Response backpressure.
    rsp_ready = 1'b0; stub_delay = 1;
    issue(4'h2, 32'h10, 32'h3, 4'h5, 32'hD, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
    check("t2_rsp_seen", found, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_data", rsp_data, 32'hD);
      check("t2_hold_tag", rsp_tag, 4'h5);
      check("t2_hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t2_idle_req_ready", req_ready, 1);
    check("t2_idle_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;

    // Back-to-back with req_valid held through the busy period.
    stub_delay = 2;
    issue(4'h3, 32'hF0F0, 32'h0FF0, 4'h1, 32'h0F00, 1'b0, 1'b1);
    issue(4'h4, 32'hF0, 32'h0F, 4'h2, 32'hFF, 1'b0, 1'b1);
    check("t3_accept_after_rsp", acc_cyc, hs_cyc + 1);
    drain(60);

    // Stale result-valid during SEND_A is ignored.
    stale_en = 1'b1; stub_delay = 3;
    issue(4'h5, 32'h100, 32'h23, 4'hA, 32'h123, 1'b0, 1'b1);
    drain(60);

    // Reset in WAIT_RES, then a normal op.
    stub_en = 1'b0;
    issue(4'h6, 32'h1, 32'h2, 4'hB, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_req_ready", req_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_to_fu", to_fu, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    check("t5_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0; stub_en = 1'b1; stub_delay = 1;
    issue(4'h7, 32'h9, 32'h4, 4'hC, 32'h24, 1'b0, 1'b1);
    drain(60);

`ifdef FU_TIMEOUT_EN
    stub_en = 1'b0; rsp_ready = 1'b0;
    issue(4'h8, 32'h1, 32'h1, 4'h7, 32'h0, 1'b1, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("tmo_no_rd", to_fu[DB+3], 0);
      if (c == 19) check("tmo_not_yet", rsp_valid, 0);
      if (c == 20) begin
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_data", rsp_data, 0);
        check("tmo_fu_hung", fu_hung, 1);
        check("tmo_req_ready", req_ready, 0);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("tmo_hung_blocks", req_ready, 0);
      check("tmo_hung_sticky", fu_hung, 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("tmo_rst_hung", fu_hung, 0);
    check("tmo_rst_req_ready", req_ready, 1);
    stub_en = 1'b1;
    @(posedge clk); #1;
`endif

    drain(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_issue_seq.md
# fu_issue_seq

Request sequencer directly upstream of the FU stage. Accepts one ALU request (opcode, two operands, tag) from decode over a valid/ready handshake and drives the FU write strobes in the fixed order ALUOP, OP1, OP2. It then waits for the external ALU's result-valid flag, issues the read-result strobe, and returns the result to writeback over a second valid/ready handshake. Only one operation is in flight; the block serialises all traffic to the FU.

## Interface

Parameters:
- `DBITS`, 32, data/operand width; equals the FU data width.
- `ALUOPBITS`, 4, opcode width.
- `TAGBITS`, 4, request tag width; the tag is returned unchanged with the response.
- `TIMEOUT_CYCLES`, 1024, watchdog limit on the wait for a result; used only with `FU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  decode has a request.
- `req_ready`  out  1  block can accept a request.
- `req_aluop`  in  ALUOPBITS  opcode.
- `req_op1`, `req_op2`  in  DBITS  operands.
- `req_tag`  in  TAGBITS  request tag.
- `to_fu`  out  DBITS+4  FU command bus.
  - [0] `wr_aluop`, [1] `wr_op1`, [2] `wr_op2`.
  - [DBITS+2:3] `wr_data`.
  - [DBITS+3] `rd_op3`.
- `from_fu`  in  DBITS+3  FU status bus.
  - [DBITS+2:DBITS] `csr_out` (csr_out[2] is result valid).
  - [DBITS-1:0] `op3`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  writeback accepts the result.
- `rsp_data`  out  DBITS  captured op3.
- `rsp_tag`  out  TAGBITS  tag of the request.
- `rsp_err`  out  1  response is a timeout; `FU_TIMEOUT_EN` only, otherwise tied 0.
- `fu_hung`  out  1  sticky timeout flag; `FU_TIMEOUT_EN` only, otherwise tied 0.

## Operation

- **Accept.** On acceptance (`req_valid && req_ready`), capture aluop, op1, op2 and tag.
- **States:** IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, READ, RESP.
- **Transitions:**
  - IDLE→SEND_OP on acceptance.
  - SEND_OP→SEND_A, SEND_A→SEND_B and SEND_B→WAIT_RES unconditionally.
  - WAIT_RES→READ when csr_out[2]=1; op3 is captured into `rsp_data` on that same edge.
  - READ→RESP unconditionally.
  - RESP→IDLE when `rsp_ready=1`.
- **Outputs are Moore and registered.**
  - `req_ready`=1 only in IDLE, and only when `fu_hung`=0.
  - SEND_OP: `wr_aluop`=1, `wr_data`={zero-extended aluop}.
  - SEND_A: `wr_op1`=1, `wr_data`=op1.
  - SEND_B: `wr_op2`=1, `wr_data`=op2.
  - READ: `rd_op3`=1.
  - RESP: `rsp_valid`=1.
  - All other strobes are 0. `wr_data`=0 outside the SEND states.
- **Strobe spacing.** At most one strobe is high per cycle. `wr_op2` always comes strictly after `wr_aluop`, because the FU discards operand readiness while it is idle.
- **READ is a separate cycle after result-valid.** The FU must have entered its result-hold state before it sees `rd_op3`. Pulsing `rd_op3` in the same cycle as csr_out[2] would deadlock.
- **Sampling.** csr_out[2] is sampled only in WAIT_RES; it is ignored in all other states. csr_out[1:0] are not used.
- **Response hold.** `rsp_data`, `rsp_tag` and `rsp_err` stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing

- **Reset values.** State=IDLE. All `to_fu` bits 0, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `rsp_err`=0, `fu_hung`=0, `req_ready`=1 from the first cycle after reset.
- **Reset mid-operation.** Abandons the operation with no response. Strobes are low from the next cycle. The FU shares `reset` and is cleared by the same edge.
- **Latency.** Acceptance edge at cycle 0:
  - `wr_aluop` high in cycle 1, `wr_op1` in cycle 2, `wr_op2` in cycle 3; WAIT_RES starts in cycle 4.
  - If csr_out[2] is first seen high in cycle k (k≥4), `rd_op3` is high in cycle k+1 and `rsp_valid` rises in cycle k+2.
- **Back-to-back.** After the RESP handshake, the block is in IDLE the next cycle. The earliest next `wr_aluop` is 2 cycles after that handshake, which guarantees the FU has returned to idle.
- **Simultaneous events.**
  - `req_valid` during a busy state is ignored; `req_ready`=0.
  - `rsp_ready` outside RESP has no effect.

## Configuration

- **Macro:** `FU_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT_RES and increments each WAIT_RES cycle.
  - If it reaches `TIMEOUT_CYCLES` with csr_out[2]=0, the block goes directly to RESP with `rsp_err`=1, `rsp_data`=0, and no `rd_op3` pulse.
  - `fu_hung` is set and stays set until reset, which blocks further requests (`req_ready`=0).
  - A result seen in the same cycle the limit is reached wins (normal path).
- **Undefined:** no counter; WAIT_RES waits indefinitely; `rsp_err` and `fu_hung` are constant 0.

## Test plan

- **Single op, ALU ready after 3 cycles.** Request aluop=0x1, op1=0x00000005, op2=0x00000007, tag=0x3; stub raises csr_out[2] with op3=0x0000000C in cycle 7. Required response:
  - strobes in cycles 1, 2, 3; `rd_op3` in cycle 8;
  - `rsp_valid` in cycle 9 with data 0x0000000C, tag 0x3.
- **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data remain stable; `req_ready`=0 throughout; IDLE the cycle after the handshake.
- **Request during busy and back-to-back.** `req_valid` held high with two requests (tags 0x1 and 0x2) → the second is accepted only in IDLE after the first response; no overlapping strobes; responses return in order.
- **Stale result-valid.** Drive csr_out[2]=1 during SEND_A → ignored; the capture happens only after WAIT_RES is entered.
- **Reset mid-operation.** Assert reset in WAIT_RES → next cycle all `to_fu` bits are 0, `rsp_valid`=0, `req_ready`=1; a new request then completes normally.
- **Timeout (`FU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16).** Never raise csr_out[2] → after 16 WAIT_RES cycles, `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0; `fu_hung`=1; `req_ready` stays 0 until reset.
